matmul_seq_ctrl: RTL and testbench

//  Sequencer for a shared single-MAC matrix-multiply datapath computing C[M][P] = A[M][N] * B[N][P].
//  - Walks row/col/idx in order and issues read addresses to the A and B operand RAMs.
//  - Drives accumulator clear/enable, then the C write strobe and address.
//  - Sits between the top-level command (start/done) and the operand RAMs + MAC; it carries no data.

---
 rtl/matmul_seq_ctrl_pkg.sv | 24 ++
 rtl/matmul_seq_ctrl_if.sv | 34 +++
 rtl/matmul_seq_ctrl_dly_line.sv | 34 +++
 rtl/matmul_seq_ctrl.sv | 175 +++++++++++++++++
 tb/tb_matmul_seq_ctrl.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/matmul_seq_ctrl_pkg.sv
// Shared types and constants for the matrix-multiply sequencer and its datapath.
package matmul_pkg;

   localparam int MM_DEF_M       = 4;
   localparam int MM_DEF_N       = 4;
   localparam int MM_DEF_P       = 4;
   localparam int MM_DEF_MEM_LAT = 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2
   } mm_state_t;

   // Address/counter width that never collapses to zero bits for a dimension of 1.
   function automatic int clog2_min1(input int value);
      if (value <= 32'sd1) begin
         return 32'sd1;
      end else begin
         return $clog2(value);
      end
   endfunction

endpackage

// File: rtl/matmul_seq_ctrl_if.sv
// Command and operand-RAM/MAC control bundle between the sequencer and the datapath.
interface matmul_seq_ctrl_if #(
   parameter int M = matmul_pkg::MM_DEF_M,
   parameter int N = matmul_pkg::MM_DEF_N,
   parameter int P = matmul_pkg::MM_DEF_P
);
   import matmul_pkg::*;

   localparam int AW_A = clog2_min1(M * N);
   localparam int AW_B = clog2_min1(N * P);
   localparam int AW_C = clog2_min1(M * P);

   logic            start;
   logic            busy;
   logic            done;
   logic            rd_en;
   logic [AW_A-1:0] a_addr;
   logic [AW_B-1:0] b_addr;
   logic            acc_en;
   logic            acc_clr;
   logic            c_wr_en;
   logic [AW_C-1:0] c_addr;

   modport master (
      input  start,
      output busy, done, rd_en, a_addr, b_addr, acc_en, acc_clr, c_wr_en, c_addr
   );

   modport slave (
      output start,
      input  busy, done, rd_en, a_addr, b_addr, acc_en, acc_clr, c_wr_en, c_addr
   );

endinterface

// File: rtl/matmul_seq_ctrl_dly_line.sv
// Reset-clearable shift register aligning issue-time tags with operand RAM read latency.
module matmul_dly_line #(
   parameter int W     = 1,
   parameter int DEPTH = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout
);

   logic [DEPTH-1:0][W-1:0] stage_q;
   logic [DEPTH-1:0][W-1:0] stage_d;

   // Next-state of every stage: shift by one toward the output.
   always_comb begin
      stage_d[0] = din;
      for (int i = 1; i < DEPTH; i++) begin
         stage_d[i] = stage_q[i-1];
      end
   end

   // Stage registers, flushed by reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stage_q <= '0;
      end else begin
         stage_q <= stage_d;
      end
   end

   assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/matmul_seq_ctrl.sv
// Sequencer for a single-MAC matrix multiply: walks row/col/idx, issues operand reads,
// and steers accumulator clear/enable plus the C write strobe. Carries no data.
module matmul_seq_ctrl
   import matmul_pkg::*;
#(
   parameter int M       = MM_DEF_M,
   parameter int N       = MM_DEF_N,
   parameter int P       = MM_DEF_P,
   parameter int MEM_LAT = MM_DEF_MEM_LAT
) (
   input  logic              clk,
   input  logic              rst,
   matmul_seq_ctrl_if.master bus
);

   localparam int AW_A = clog2_min1(M * N);
   localparam int AW_B = clog2_min1(N * P);
   localparam int AW_C = clog2_min1(M * P);
   localparam int RW   = clog2_min1(M);
   localparam int CW   = clog2_min1(P);
   localparam int IW   = clog2_min1(N);
   localparam int DW   = AW_C + 3;

   localparam logic [RW-1:0]   ROW_MAX    = RW'(M - 1);
   localparam logic [CW-1:0]   COL_MAX    = CW'(P - 1);
   localparam logic [IW-1:0]   IDX_MAX    = IW'(N - 1);
   localparam logic [AW_C-1:0] C_LAST     = AW_C'(M * P - 1);
   localparam logic [AW_A-1:0] A_ROW_STEP = AW_A'(N);
   localparam logic [AW_B-1:0] B_IDX_STEP = AW_B'(P);

   if (M < 1 || N < 1 || P < 1 || MEM_LAT < 1) begin : g_param_check
      $fatal(1, "matmul_seq_ctrl: M, N, P and MEM_LAT must all be >= 1");
   end

   mm_state_t       state_q, state_d;
   logic            busy_q, busy_d, done_q, done_d, rd_en_q, rd_en_d;
   logic [AW_A-1:0] a_addr_q, a_addr_d, a_base_q, a_base_d;
   logic [AW_B-1:0] b_addr_q, b_addr_d;
   logic [RW-1:0]   row_q, row_d;
   logic [CW-1:0]   col_q, col_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic [AW_C-1:0] c_cur_q, c_cur_d, c_addr_q, c_addr_d;
   logic            c_wr_en_q, c_wr_en_d;
   logic [DW-1:0]   dly_in, dly_out;
   logic            last_issue;

   // Tag = {valid, first-of-dot-product, last-of-dot-product, C address}, gated when idle.
   assign dly_in     = {rd_en_q, rd_en_q & (idx_q == '0), rd_en_q & (idx_q == IDX_MAX),
                        rd_en_q ? c_cur_q : {AW_C{1'b0}}};
   assign last_issue = (row_q == ROW_MAX) && (col_q == COL_MAX) && (idx_q == IDX_MAX);

   matmul_dly_line #(.W(DW), .DEPTH(MEM_LAT)) u_dly (
      .clk  (clk),
      .rst  (rst),
      .din  (dly_in),
      .dout (dly_out)
   );

   // Next-state, loop-nest advance and registered strobe computation.
   always_comb begin
      state_d   = state_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      rd_en_d   = 1'b0;
      a_addr_d  = '0;
      b_addr_d  = '0;
      a_base_d  = a_base_q;
      row_d     = row_q;
      col_d     = col_q;
      idx_d     = idx_q;
      c_cur_d   = c_cur_q;
      c_wr_en_d = dly_out[DW-1] & dly_out[DW-3];
      c_addr_d  = c_wr_en_d ? dly_out[AW_C-1:0] : {AW_C{1'b0}};
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d  = ISSUE;
               busy_d   = 1'b1;
               rd_en_d  = 1'b1;
               a_base_d = '0;
               row_d    = '0;
               col_d    = '0;
               idx_d    = '0;
               c_cur_d  = '0;
            end else begin
               busy_d = 1'b0;
            end
         end
         ISSUE: begin
            if (last_issue) begin
               state_d = DRAIN;
            end else if (idx_q != IDX_MAX) begin
               rd_en_d  = 1'b1;
               idx_d    = idx_q + 1'b1;
               a_addr_d = a_addr_q + 1'b1;
               b_addr_d = b_addr_q + B_IDX_STEP;
            end else if (col_q != COL_MAX) begin
               // New column of the same row: A rewinds to the row base, B restarts at col.
               rd_en_d  = 1'b1;
               idx_d    = '0;
               col_d    = col_q + 1'b1;
               a_addr_d = a_base_q;
               b_addr_d = AW_B'(col_q) + 1'b1;
               c_cur_d  = c_cur_q + 1'b1;
            end else begin
               rd_en_d  = 1'b1;
               idx_d    = '0;
               col_d    = '0;
               row_d    = row_q + 1'b1;
               a_base_d = a_base_q + A_ROW_STEP;
               a_addr_d = a_base_q + A_ROW_STEP;
               b_addr_d = '0;
               c_cur_d  = c_cur_q + 1'b1;
            end
         end
         DRAIN: begin
            if (c_wr_en_q && (c_addr_q == C_LAST)) begin
               state_d = IDLE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end else begin
               state_d = DRAIN;
            end
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // All sequencer state and outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         rd_en_q   <= 1'b0;
         a_addr_q  <= '0;
         b_addr_q  <= '0;
         a_base_q  <= '0;
         row_q     <= '0;
         col_q     <= '0;
         idx_q     <= '0;
         c_cur_q   <= '0;
         c_wr_en_q <= 1'b0;
         c_addr_q  <= '0;
      end else begin
         state_q   <= state_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         rd_en_q   <= rd_en_d;
         a_addr_q  <= a_addr_d;
         b_addr_q  <= b_addr_d;
         a_base_q  <= a_base_d;
         row_q     <= row_d;
         col_q     <= col_d;
         idx_q     <= idx_d;
         c_cur_q   <= c_cur_d;
         c_wr_en_q <= c_wr_en_d;
         c_addr_q  <= c_addr_d;
      end
   end

   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
   assign bus.rd_en   = rd_en_q;
   assign bus.a_addr  = a_addr_q;
   assign bus.b_addr  = b_addr_q;
   assign bus.acc_en  = dly_out[DW-1];
   assign bus.acc_clr = dly_out[DW-2];
   assign bus.c_wr_en = c_wr_en_q;
   assign bus.c_addr  = c_addr_q;

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// Scoreboard bench for matmul_seq_ctrl over four dimension/latency configurations.
module tb_matmul_seq_ctrl;

   typedef struct packed {
      logic       busy;
      logic       done;
      logic       rd_en;
      logic       acc_en;
      logic       acc_clr;
      logic       c_wr_en;
      logic [7:0] a_addr;
      logic [7:0] b_addr;
      logic [7:0] c_addr;
   } obs_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_checks = 0;
   int   n_fail = 0;
   obs_t exp_q[$];
   obs_t obs0, obs1, obs2, obs3;

   always #5 clk = ~clk;

   matmul_seq_ctrl_if #(.M(4), .N(4), .P(4)) if0 ();
   matmul_seq_ctrl_if #(.M(2), .N(3), .P(2)) if1 ();
   matmul_seq_ctrl_if #(.M(1), .N(1), .P(1)) if2 ();
   matmul_seq_ctrl_if #(.M(2), .N(1), .P(3)) if3 ();

   matmul_seq_ctrl #(.M(4), .N(4), .P(4), .MEM_LAT(1)) dut0 (.clk(clk), .rst(rst), .bus(if0.master));
   matmul_seq_ctrl #(.M(2), .N(3), .P(2), .MEM_LAT(3)) dut1 (.clk(clk), .rst(rst), .bus(if1.master));
   matmul_seq_ctrl #(.M(1), .N(1), .P(1), .MEM_LAT(1)) dut2 (.clk(clk), .rst(rst), .bus(if2.master));
   matmul_seq_ctrl #(.M(2), .N(1), .P(3), .MEM_LAT(1)) dut3 (.clk(clk), .rst(rst), .bus(if3.master));

   always_comb obs0 = {if0.busy, if0.done, if0.rd_en, if0.acc_en, if0.acc_clr, if0.c_wr_en,
                       8'(if0.a_addr), 8'(if0.b_addr), 8'(if0.c_addr)};
   always_comb obs1 = {if1.busy, if1.done, if1.rd_en, if1.acc_en, if1.acc_clr, if1.c_wr_en,
                       8'(if1.a_addr), 8'(if1.b_addr), 8'(if1.c_addr)};
   always_comb obs2 = {if2.busy, if2.done, if2.rd_en, if2.acc_en, if2.acc_clr, if2.c_wr_en,
                       8'(if2.a_addr), 8'(if2.b_addr), 8'(if2.c_addr)};
   always_comb obs3 = {if3.busy, if3.done, if3.rd_en, if3.acc_en, if3.acc_clr, if3.c_wr_en,
                       8'(if3.a_addr), 8'(if3.b_addr), 8'(if3.c_addr)};

   // Expected outputs for cycles 1..T+L+2 of one operation started at edge 0.
   function automatic void push_trace(input int m, input int n, input int p, input int l);
      int   t;
      int   k;
      obs_t e;
      t = m * n * p;
      for (int c = 1; c <= t + l + 2; c++) begin
         e = '0;
         e.busy = (c <= t + l + 1);
         e.done = (c == t + l + 2);
         if (c <= t) begin
            k = c - 1;
            e.rd_en  = 1'b1;
            e.a_addr = 8'((k / (n * p)) * n + k % n);
            e.b_addr = 8'((k % n) * p + (k / n) % p);
         end
         if (c - l >= 1 && c - l <= t) begin
            k = c - l - 1;
            e.acc_en  = 1'b1;
            e.acc_clr = (k % n == 0);
         end
         if (c - l - 1 >= 1 && c - l - 1 <= t) begin
            k = c - l - 2;
            if (k % n == n - 1) begin
               e.c_wr_en = 1'b1;
               e.c_addr  = 8'((k / (n * p)) * p + (k / n) % p);
            end
         end
         exp_q.push_back(e);
      end
   endfunction

   function automatic void push_idle(input int cycles);
      for (int i = 0; i < cycles; i++) exp_q.push_back('0);
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      n_checks += 4;
      if (obs0 !== '0) begin n_fail++; $display("FAIL reset0 got=%h exp=0", obs0); end
      if (obs1 !== '0) begin n_fail++; $display("FAIL reset1 got=%h exp=0", obs1); end
      if (obs2 !== '0) begin n_fail++; $display("FAIL reset2 got=%h exp=0", obs2); end
      if (obs3 !== '0) begin n_fail++; $display("FAIL reset3 got=%h exp=0", obs3); end
      rst = 1'b0;
      repeat (2) @(negedge clk);
      n_checks += 4;
      if (obs0 !== '0) begin n_fail++; $display("FAIL idle0 got=%h exp=0", obs0); end
      if (obs1 !== '0) begin n_fail++; $display("FAIL idle1 got=%h exp=0", obs1); end
      if (obs2 !== '0) begin n_fail++; $display("FAIL idle2 got=%h exp=0", obs2); end
      if (obs3 !== '0) begin n_fail++; $display("FAIL idle3 got=%h exp=0", obs3); end
   endtask

   task automatic test_default();
      obs_t e;
      exp_q.delete();
      push_trace(4, 4, 4, 1);
      push_idle(2);
      @(negedge clk);
      if0.start = 1'b1;
      for (int c = 1; exp_q.size() > 0; c++) begin
         @(negedge clk);
         if0.start = 1'b0;
         e = exp_q.pop_front();
         n_checks++;
         if (obs0 !== e) begin n_fail++; $display("FAIL default cyc=%0d got=%h exp=%h", c, obs0, e); end
      end
   endtask

   task automatic test_lat3();
      obs_t e;
      exp_q.delete();
      push_trace(2, 3, 2, 3);
      push_idle(2);
      @(negedge clk);
      if1.start = 1'b1;
      for (int c = 1; exp_q.size() > 0; c++) begin
         @(negedge clk);
         if1.start = 1'b0;
         e = exp_q.pop_front();
         n_checks++;
         if (obs1 !== e) begin n_fail++; $display("FAIL lat3 cyc=%0d got=%h exp=%h", c, obs1, e); end
      end
   endtask

   task automatic test_unit();
      obs_t e;
      exp_q.delete();
      push_trace(1, 1, 1, 1);
      push_idle(2);
      @(negedge clk);
      if2.start = 1'b1;
      for (int c = 1; exp_q.size() > 0; c++) begin
         @(negedge clk);
         if2.start = 1'b0;
         e = exp_q.pop_front();
         n_checks++;
         if (obs2 !== e) begin n_fail++; $display("FAIL unit cyc=%0d got=%h exp=%h", c, obs2, e); end
      end
   endtask

   task automatic test_n1();
      obs_t e;
      exp_q.delete();
      push_trace(2, 1, 3, 1);
      push_idle(2);
      @(negedge clk);
      if3.start = 1'b1;
      for (int c = 1; exp_q.size() > 0; c++) begin
         @(negedge clk);
         if3.start = 1'b0;
         e = exp_q.pop_front();
         n_checks++;
         if (obs3 !== e) begin n_fail++; $display("FAIL n1 cyc=%0d got=%h exp=%h", c, obs3, e); end
      end
   endtask

   // start held high: the second run must begin right after the first done, then stop.
   task automatic test_back_to_back();
      obs_t e;
      exp_q.delete();
      push_trace(4, 4, 4, 1);
      push_trace(4, 4, 4, 1);
      push_idle(2);
      @(negedge clk);
      if0.start = 1'b1;
      for (int c = 1; exp_q.size() > 0; c++) begin
         @(negedge clk);
         e = exp_q.pop_front();
         n_checks++;
         if (obs0 !== e) begin n_fail++; $display("FAIL b2b cyc=%0d got=%h exp=%h", c, obs0, e); end
         if (exp_q.size() == 2) if0.start = 1'b0;
      end
      if0.start = 1'b0;
   endtask

   task automatic test_reset_mid();
      obs_t e;
      exp_q.delete();
      push_trace(4, 4, 4, 1);
      @(negedge clk);
      if0.start = 1'b1;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         if0.start = 1'b0;
         e = exp_q.pop_front();
         n_checks++;
         if (obs0 !== e) begin n_fail++; $display("FAIL pre_rst cyc=%0d got=%h exp=%h", c, obs0, e); end
      end
      rst = 1'b1;
      #1;
      n_checks++;
      if (obs0 !== '0) begin n_fail++; $display("FAIL rst_async got=%h exp=0", obs0); end
      exp_q.delete();
      @(negedge clk);
      rst = 1'b0;
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk);
         n_checks++;
         if (obs0 !== '0) begin n_fail++; $display("FAIL rst_quiet cyc=%0d got=%h exp=0", c, obs0); end
      end
      test_default();
   endtask

   initial begin
      if0.start = 1'b0;
      if1.start = 1'b0;
      if2.start = 1'b0;
      if3.start = 1'b0;
      test_reset();
      test_default();
      test_lat3();
      test_unit();
      test_n1();
      test_back_to_back();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
